flex_baud_gen: RTL and testbench

Programmable fractional baud-rate generator for the flex-UART, replacing the fixed-frequency vendor PLL clock with an on-fabric numerically controlled oscillator (NCO) running directly from the reference clock. It produces single-cycle oversample and baud tick enables at a rate set at runtime through a valid/ready configuration port, plus a lock indication. Transmit and receive engines use these enables in the `refclk` domain, so the UART needs no second clock domain.

---
 rtl/flex_baud_if.sv | 40 ++++
 rtl/flex_baud_gen.sv | 131 +++++++++++++
 tb/tb_flex_baud_gen.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/flex_baud_if.sv
// ============================================================================
// Module   : flex_baud_if
// Brief    : Configuration handshake and tick outputs of the flex-UART NCO.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface flex_baud_if #(
    parameter int ACC_W = 24
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_inc;
    logic             tick_os;
    logic             tick_baud;
    logic             locked;
    logic             outclk;

    modport master (
        output cfg_valid,
        output cfg_inc,
        input  cfg_ready,
        input  tick_os,
        input  tick_baud,
        input  locked,
        input  outclk
    );

    modport slave (
        input  cfg_valid,
        input  cfg_inc,
        output cfg_ready,
        output tick_os,
        output tick_baud,
        output locked,
        output outclk
    );
endinterface

`default_nettype wire

// File: rtl/flex_baud_gen.sv
// ============================================================================
// Module   : flex_baud_gen
// Brief    : Fractional NCO baud generator producing oversample/baud enables
//            in the refclk domain. FLEX_BAUD_CLKOUT_EN builds the outclk flop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module flex_baud_gen #(
    parameter int ACC_W      = 24,
    parameter int OVERSAMPLE = 16,
    parameter int LOCK_TICKS = 4
) (
    input  wire logic  refclk,
    input  wire logic  rst_n,
    flex_baud_if.slave bus
);
    localparam int c_OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int c_LK_W = $clog2(LOCK_TICKS + 1);
    localparam logic [c_OS_W-1:0] c_OS_LAST = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_LK_W-1:0] c_LK_DONE = c_LK_W'(LOCK_TICKS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_inc;
    logic [ACC_W-1:0]   r_acc;
    logic [c_OS_W-1:0]  r_os_cnt;
    logic [c_LK_W-1:0]  r_lock_cnt;
    logic               r_tick_os;
    logic               r_tick_baud;
    logic               r_locked;

    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    logic               w_os_wrap;
    logic               w_cfg_ready;
    logic               w_accept;
    logic [c_LK_W-1:0]  w_lock_next;

    assign w_sum       = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry     = w_sum[ACC_W];
    assign w_os_wrap   = w_carry && (r_os_cnt == c_OS_LAST);
    assign w_cfg_ready = (r_state != S_LOAD);
    assign w_accept    = bus.cfg_valid && w_cfg_ready;
    assign w_lock_next = r_lock_cnt + c_LK_W'(1);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_inc       <= '0;
            r_acc       <= '0;
            r_os_cnt    <= '0;
            r_lock_cnt  <= '0;
            r_tick_os   <= 1'b0;
            r_tick_baud <= 1'b0;
            r_locked    <= 1'b0;
        end else if (w_accept) begin
            // Reconfiguration wins over accumulation; LOAD does the clearing.
            r_inc       <= bus.cfg_inc;
            r_state     <= S_LOAD;
            r_tick_os   <= 1'b0;
            r_tick_baud <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tick_os   <= 1'b0;
                    r_tick_baud <= 1'b0;
                    r_locked    <= 1'b0;
                end
                S_LOAD: begin
                    r_acc       <= '0;
                    r_os_cnt    <= '0;
                    r_lock_cnt  <= '0;
                    r_tick_os   <= 1'b0;
                    r_tick_baud <= 1'b0;
                    r_locked    <= 1'b0;
                    r_state     <= (r_inc != '0) ? S_SETTLE : S_IDLE;
                end
                S_SETTLE, S_RUN: begin
                    r_acc       <= w_sum[ACC_W-1:0];
                    r_tick_os   <= w_carry;
                    r_tick_baud <= w_os_wrap;
                    if (w_carry) begin
                        r_os_cnt <= w_os_wrap ? '0 : r_os_cnt + c_OS_W'(1);
                    end
                    if ((r_state == S_SETTLE) && w_os_wrap) begin
                        r_lock_cnt <= w_lock_next;
                        if (w_lock_next == c_LK_DONE) begin
                            r_state  <= S_RUN;
                            r_locked <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cfg_ready = w_cfg_ready;
    assign bus.tick_os   = r_tick_os;
    assign bus.tick_baud = r_tick_baud;
    assign bus.locked    = r_locked;

`ifdef FLEX_BAUD_CLKOUT_EN
    logic r_outclk;

    // Toggle on each oversample pulse: square wave at half the oversample rate.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_outclk <= 1'b0;
        end else if ((r_state == S_SETTLE) || (r_state == S_RUN)) begin
            r_outclk <= r_outclk ^ r_tick_os;
        end else begin
            r_outclk <= 1'b0;
        end
    end

    assign bus.outclk = r_outclk;
`else
    assign bus.outclk = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_flex_baud_gen.sv
// ============================================================================
// Module   : tb_flex_baud_gen
// Brief    : Scoreboard bench for flex_baud_gen (ACC_W=8, OVERSAMPLE=4, LOCK_TICKS=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_flex_baud_gen;
    localparam int c_ACC_W = 8;
    localparam int c_OS    = 4;
    localparam int c_LOCK  = 2;

    typedef struct {
        bit   care;
        logic os;
        logic baud;
        logic lk;
        logic rdy;
        logic oc;
    } exp_t;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;
    exp_t q_exp[$];

    flex_baud_if #(.ACC_W(c_ACC_W)) bus ();

    flex_baud_gen #(
        .ACC_W      (c_ACC_W),
        .OVERSAMPLE (c_OS),
        .LOCK_TICKS (c_LOCK)
    ) u_dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: ticks derived in closed form from the cycle count since LOAD.
    int     m_state  = 0;   // 0 idle, 1 load, 2 accumulating
    longint m_inc    = 0;
    longint m_n      = 0;
    longint m_carries = 0;

    always @(posedge refclk or negedge rst_n) begin
        exp_t e;
        longint c;
        if (!rst_n) begin
            m_state = 0; m_inc = 0; m_n = 0; m_carries = 0;
            q_exp.delete();
        end else begin
            e = '{care: 1'b1, os: 1'b0, baud: 1'b0, lk: 1'b0, rdy: 1'b1, oc: 1'b0};
            if (bus.cfg_valid && m_state != 1) begin
                m_inc   = longint'(bus.cfg_inc);
                m_state = 1;
                e.care  = 1'b0;
                e.rdy   = 1'b0;
            end else if (m_state == 1) begin
                m_state   = (m_inc != 0) ? 2 : 0;
                m_n       = 0;
                m_carries = 0;
            end else if (m_state == 2) begin
`ifdef FLEX_BAUD_CLKOUT_EN
                e.oc = logic'(m_carries[0]);
`endif
                m_n++;
                c = ((m_n * m_inc) >> c_ACC_W) - (((m_n - 1) * m_inc) >> c_ACC_W);
                if (c != 0) m_carries++;
                e.os   = (c != 0);
                e.baud = (c != 0) && (m_carries % c_OS == 0);
                e.lk   = (m_carries >= c_OS * c_LOCK);
            end
            q_exp.push_back(e);
        end
    end

    always @(negedge refclk) begin
        exp_t e;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk("cfg_ready", 32'(bus.cfg_ready), 32'(e.rdy));
            if (e.care) begin
                chk("tick_os",   32'(bus.tick_os),   32'(e.os));
                chk("tick_baud", 32'(bus.tick_baud), 32'(e.baud));
                chk("locked",    32'(bus.locked),    32'(e.lk));
                chk("outclk",    32'(bus.outclk),    32'(e.oc));
            end
        end
    end

    task automatic configure(input logic [c_ACC_W-1:0] v);
        @(negedge refclk);
        bus.cfg_valid = 1'b1;
        bus.cfg_inc   = v;
        @(negedge refclk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) @(negedge refclk);
    endtask

    task automatic count_ticks(input int n, output int cnt, output bit iv_ok);
        int last;
        last  = -1;
        cnt   = 0;
        iv_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge refclk);
            if (bus.tick_os) begin
                if (last >= 0 && (i - last < 2 || i - last > 3)) iv_ok = 1'b0;
                last = i;
                cnt++;
            end
        end
    endtask

    initial begin
        int  cnt;
        bit  iv_ok;
        bus.cfg_valid = 1'b0;
        bus.cfg_inc   = '0;
        run(3);
        chk("rst_ready",  32'(bus.cfg_ready), 32'd1);
        chk("rst_tick",   32'(bus.tick_os),   32'd0);
        chk("rst_locked", 32'(bus.locked),    32'd0);
        rst_n = 1'b1;
        run(3);

        // Integer rate: 4-cycle oversample, 16-cycle baud, lock after 32 cycles.
        configure(8'd64);
        run(40);
        chk("locked_64", 32'(bus.locked), 32'd1);

        // Mid-RUN reconfiguration to an 8-cycle period.
        configure(8'd32);
        run(1);
        chk("locked_drop", 32'(bus.locked), 32'd0);
        run(80);
        chk("locked_32", 32'(bus.locked), 32'd1);

        // Fractional rate.
        configure(8'd96);
        run(10);
        count_ticks(256, cnt, iv_ok);
        chk("frac_count", 32'(cnt), 32'd96);
        chk("frac_interval", 32'(iv_ok), 32'd1);

        // Stop.
        configure(8'd0);
        run(2);
        count_ticks(1000, cnt, iv_ok);
        chk("stop_count", 32'(cnt), 32'd0);
        chk("stop_ready", 32'(bus.cfg_ready), 32'd1);
        chk("stop_locked", 32'(bus.locked), 32'd0);

        // Near-maximum rate.
        configure(8'd255);
        run(5);
        count_ticks(256, cnt, iv_ok);
        chk("max_count", 32'(cnt), 32'd255);

        // Asynchronous reset mid-RUN.
        configure(8'd64);
        run(50);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready",  32'(bus.cfg_ready), 32'd1);
        chk("arst_os",     32'(bus.tick_os),   32'd0);
        chk("arst_baud",   32'(bus.tick_baud), 32'd0);
        chk("arst_locked", 32'(bus.locked),    32'd0);
        chk("arst_outclk", 32'(bus.outclk),    32'd0);
        run(3);
        rst_n = 1'b1;
        run(5);
        chk("post_rst_tick", 32'(bus.tick_os), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
